// File: rtl/arducam_pkg.sv
// Shared types and constants for the ArduCAM burst FIFO reader.
package arducam_pkg;
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    READ,
    HOLD,
    FINISH
  } state_t;

  localparam logic [7:0] ARDUCAM_CMD_BURST      = 8'h3C;
  localparam logic [7:0] ARDUCAM_CMD_FIFO_CLEAR = 8'h01;
  localparam int         ARDUCAM_LEN_W          = 23;
endpackage

// File: rtl/spi_byte_engine.sv
// One SPI mode-0 byte transfer: clock divider, MOSI/MISO shift registers.
// A go presented in the byte_done cycle chains the next byte with no gap.
module spi_byte_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_go,
  input  logic [7:0] i_tx_byte,
  output logic [7:0] o_rx_byte,
  output logic       o_byte_done,
  output logic       o_sclk,
  output logic       o_mosi,
  input  logic       i_miso
);
  logic       r_active;
  logic [7:0] r_div;
  logic [2:0] r_bit;
  logic       r_sclk;
  logic       r_mosi;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic       w_half_end;

  assign w_half_end  = (r_div == 8'(CLK_DIV - 1));
  assign o_byte_done = r_active && r_sclk && w_half_end && (r_bit == 3'd7);
  assign o_rx_byte   = r_rx;
  assign o_sclk      = r_sclk;
  assign o_mosi      = r_mosi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b0;
      r_tx     <= '0;
      r_rx     <= '0;
    end else if (!r_active) begin
      if (i_go) begin
        r_active <= 1'b1;
        r_div    <= '0;
        r_bit    <= '0;
        r_tx     <= i_tx_byte;
        r_mosi   <= i_tx_byte[7];
      end
    end else if (w_half_end) begin
      r_div <= '0;
      if (!r_sclk) begin
        r_sclk <= 1'b1;
        r_rx   <= {r_rx[6:0], i_miso};
      end else begin
        r_sclk <= 1'b0;
        if (r_bit == 3'd7) begin
          // Falling edge closes the byte; optionally chain straight into the next.
          if (i_go) begin
            r_bit  <= '0;
            r_tx   <= i_tx_byte;
            r_mosi <= i_tx_byte[7];
          end else begin
            r_active <= 1'b0;
            r_mosi   <= 1'b0;
          end
        end else begin
          r_bit  <= r_bit + 3'd1;
          r_mosi <= r_tx[6];
          r_tx   <= {r_tx[6:0], 1'b0};
        end
      end
    end else begin
      r_div <= r_div + 8'd1;
    end
  end
endmodule

// File: rtl/arducam_burst_reader.sv
// SPI master draining the ArduCAM frame FIFO via burst read onto valid/ready.
// Optional abort input enabled by defining ABORT_EN.
module arducam_burst_reader
  import arducam_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter int         LEN_W     = ARDUCAM_LEN_W,
  parameter logic [7:0] BURST_CMD = ARDUCAM_CMD_BURST
) (
  input  logic             clk,
  input  logic             reset_rtl_0,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
`ifdef ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             camera_spi_sclk,
  output logic             camera_spi_mosi,
  input  logic             camera_spi_miso,
  output logic             camera_spi_ss
);
  state_t           r_state;
  logic [LEN_W-1:0] r_rem;
  logic [7:0]       r_cnt;
  logic             r_ss, r_busy, r_done, r_mvalid;
  logic [7:0]       r_mdata;
  logic             w_go, w_bdone, w_free, w_more, w_abort, w_deliver, w_cnt_end;
  logic [7:0]       w_tx, w_rx;

`ifdef ABORT_EN
  logic r_abort;
  always_ff @(posedge clk) begin
    if (reset_rtl_0 || r_state == IDLE) r_abort <= 1'b0;
    else if (abort)                     r_abort <= 1'b1;
  end
  assign w_abort = r_abort || (abort && r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_cnt_end = (r_cnt == 8'(CLK_DIV - 1));
  assign w_free    = !r_mvalid || m_ready;
  assign w_more    = (r_rem != LEN_W'(1)) && !w_abort;
  assign w_deliver = ((r_state == READ) && w_bdone && w_free) || ((r_state == HOLD) && w_free);
  assign w_go      = ((r_state == SETUP) && w_cnt_end) ||
                     ((r_state == CMD) && w_bdone && !w_abort) ||
                     (w_deliver && w_more);
  assign w_tx      = (r_state == SETUP) ? BURST_CMD : 8'h00;

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .i_clk       (clk),
    .i_rst       (reset_rtl_0),
    .i_go        (w_go),
    .i_tx_byte   (w_tx),
    .o_rx_byte   (w_rx),
    .o_byte_done (w_bdone),
    .o_sclk      (camera_spi_sclk),
    .o_mosi      (camera_spi_mosi),
    .i_miso      (camera_spi_miso)
  );

  always_ff @(posedge clk) begin
    if (reset_rtl_0) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_ss     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_mvalid && m_ready) r_mvalid <= 1'b0;
      if (w_deliver) begin
        r_mdata  <= w_rx;
        r_mvalid <= 1'b1;
        r_rem    <= r_rem - LEN_W'(1);
      end
      case (r_state)
        IDLE: if (start) begin
          if (length != '0) begin
            r_rem   <= length;
            r_busy  <= 1'b1;
            r_ss    <= 1'b0;
            r_cnt   <= '0;
            r_state <= SETUP;
          end else begin
            r_done <= 1'b1;
          end
        end
        SETUP: if (w_cnt_end) r_state <= CMD;
               else           r_cnt   <= r_cnt + 8'd1;
        CMD: if (w_bdone) begin
          r_cnt   <= '0;
          r_state <= w_abort ? FINISH : READ;
        end
        READ: if (w_bdone) begin
          r_cnt <= '0;
          if (!w_free)      r_state <= HOLD;
          else if (!w_more) r_state <= FINISH;
        end
        // sclk is parked low here; the byte sits in the engine until downstream frees up
        HOLD: if (w_free) begin
          r_cnt   <= '0;
          r_state <= w_more ? READ : FINISH;
        end
        FINISH: if (w_cnt_end) begin
          r_ss    <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign m_data        = r_mdata;
  assign m_valid       = r_mvalid;
  assign camera_spi_ss = r_ss;
endmodule

// File: tb/tb_arducam_burst_reader.sv
// Directed bench for arducam_burst_reader (CLK_DIV=2) with a camera MISO model.
module tb_arducam_burst_reader;
  localparam int LEN_W = 23;

  logic             clk = 1'b0;
  logic             reset_rtl_0 = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] length = '0;
  logic             busy, done, m_valid;
  logic [7:0]       m_data;
  logic             m_ready = 1'b1;
  logic             sclk, mosi, ss;
  logic             miso = 1'b0;
`ifdef ABORT_EN
  logic             abort = 1'b0;
`endif

  arducam_burst_reader #(.CLK_DIV(2), .LEN_W(LEN_W), .BURST_CMD(8'h3C)) dut (
    .clk             (clk),
    .reset_rtl_0     (reset_rtl_0),
    .start           (start),
    .length          (length),
`ifdef ABORT_EN
    .abort           (abort),
`endif
    .busy            (busy),
    .done            (done),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .camera_spi_sclk (sclk),
    .camera_spi_mosi (mosi),
    .camera_spi_miso (miso),
    .camera_spi_ss   (ss)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Monitor and MISO model, all sampled on the falling clk edge.
  int cyc = 0, rises = 0, falls = 0, ss_low = 0, done_cnt = 0, done_busy = 0, tog = 0;
  int last_fall = 0, ss_rise = 0, mosi_n = 0, fall_base = 0;
  logic p_sclk = 1'b0, p_ss = 1'b1, p_busy = 1'b0;
  logic [7:0] mosi_sh = 8'h00;
  logic [7:0] acc_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] pat[8];

  always @(negedge clk) begin
    int idx, b;
    cyc++;
    if (m_valid === 1'b1 && m_ready) acc_q.push_back(m_data);
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0) done_busy++;
    end
    if (ss === 1'b0) ss_low++;
    if (sclk === 1'b1 && p_sclk === 1'b0) begin
      rises++;
      mosi_sh = {mosi_sh[6:0], mosi};
      mosi_n++;
      if (mosi_n % 8 == 0) mosi_q.push_back(mosi_sh);
    end
    if (sclk === 1'b0 && p_sclk === 1'b1) begin
      falls++;
      last_fall = cyc;
    end
    if (ss === 1'b1 && p_ss === 1'b0) ss_rise = cyc;
    if (sclk !== p_sclk || ss !== p_ss || busy !== p_busy) tog++;
    p_sclk = sclk;
    p_ss   = ss;
    p_busy = busy;
    idx = falls - fall_base;
    b   = idx / 8;
    miso = (b >= 1 && b <= 8) ? pat[b-1][7 - (idx % 8)] : 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int len);
    @(posedge clk); #1;
    start  = 1'b1;
    length = LEN_W'(len);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int maxc);
    int n;
    n = 0;
    while (done_cnt == d0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, (done_cnt > d0) ? 32'd1 : 32'd0, 32'd1);
    cycles(3);
  endtask

  task automatic wait_acc(input string tag, input int target, input int maxc);
    int n;
    n = 0;
    while (acc_q.size() < target && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, (acc_q.size() >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int a0, r0, d0, s0, t0;
    pat = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cycles(4);
    @(negedge clk);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mvalid", 32'(m_valid), 32'd0);
    chk("rst_mdata", 32'(m_data), 32'd0);
    @(posedge clk); #1;
    reset_rtl_0 = 1'b0;
    cycles(3);

    // Full-rate burst of 4
    a0 = acc_q.size(); r0 = rises; d0 = done_cnt; s0 = ss_low; fall_base = falls;
    pulse_start(4);
    wait_done("t1_timeout", d0, 2000);
    chk("t1_nbytes", 32'(acc_q.size() - a0), 32'd4);
    chk("t1_b0", 32'(acc_q[a0]), 32'hA5);
    chk("t1_b1", 32'(acc_q[a0+1]), 32'h5A);
    chk("t1_b2", 32'(acc_q[a0+2]), 32'hFF);
    chk("t1_b3", 32'(acc_q[a0+3]), 32'h00);
    chk("t1_nmosi", 32'(mosi_q.size()), 32'd5);
    chk("t1_mosi0", 32'(mosi_q[0]), 32'h3C);
    chk("t1_mosi_rest", 32'(mosi_q[1] | mosi_q[2] | mosi_q[3] | mosi_q[4]), 32'h00);
    chk("t1_rises", 32'(rises - r0), 32'd40);
    chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t1_done_busy", 32'(done_busy), 32'd0);
    chk("t1_ss_low", 32'(ss_low - s0), 32'd164);
    chk("t1_ss_tail", 32'(ss_rise - last_fall), 32'd2);
    chk("t1_ss_end", 32'(ss), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Backpressure: byte 2 parks in m_data, byte 3 waits with sclk low
    a0 = acc_q.size(); r0 = rises; d0 = done_cnt; fall_base = falls;
    pulse_start(4);
    wait_acc("t2_first", a0 + 1, 500);
    m_ready = 1'b0;
    cycles(200);
    @(negedge clk);
    chk("t2_stall_rises", 32'(rises - r0), 32'd32);
    chk("t2_stall_sclk", 32'(sclk), 32'd0);
    chk("t2_stall_ss", 32'(ss), 32'd0);
    chk("t2_stall_mvalid", 32'(m_valid), 32'd1);
    chk("t2_stall_mdata", 32'(m_data), 32'h5A);
    chk("t2_stall_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done("t2_timeout", d0, 2000);
    chk("t2_nbytes", 32'(acc_q.size() - a0), 32'd4);
    chk("t2_bytes", {acc_q[a0], acc_q[a0+1], acc_q[a0+2], acc_q[a0+3]}, 32'hA55AFF00);
    chk("t2_rises", 32'(rises - r0), 32'd40);
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Zero length: immediate done, no bus activity
    t0 = tog; d0 = done_cnt;
    pulse_start(0);
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t3_done_off", 32'(done), 32'd0);
    chk("t3_toggles", 32'(tog - t0), 32'd0);
    chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Start while busy is ignored
    a0 = acc_q.size(); r0 = rises; d0 = done_cnt; fall_base = falls;
    pulse_start(4);
    cycles(50);
    pulse_start(9);
    wait_done("t4_timeout", d0, 2000);
    cycles(100);
    chk("t4_nbytes", 32'(acc_q.size() - a0), 32'd4);
    chk("t4_rises", 32'(rises - r0), 32'd40);
    chk("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);

    // Reset during byte 3, then a fresh burst
    a0 = acc_q.size(); fall_base = falls;
    pulse_start(4);
    wait_acc("t5_two", a0 + 2, 500);
    cycles(10);
    reset_rtl_0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_ss", 32'(ss), 32'd1);
    chk("t5_sclk", 32'(sclk), 32'd0);
    chk("t5_mvalid", 32'(m_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    #1;
    reset_rtl_0 = 1'b0;
    cycles(3);
    pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    a0 = acc_q.size(); r0 = rises; d0 = done_cnt; fall_base = falls;
    pulse_start(4);
    wait_done("t5_timeout", d0, 2000);
    chk("t5_nbytes", 32'(acc_q.size() - a0), 32'd4);
    chk("t5_bytes", {acc_q[a0], acc_q[a0+1], acc_q[a0+2], acc_q[a0+3]}, 32'h11223344);
    chk("t5_rises", 32'(rises - r0), 32'd40);

`ifdef ABORT_EN
    // Abort during byte 5 of a 100-byte burst
    pat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    a0 = acc_q.size(); d0 = done_cnt; fall_base = falls;
    pulse_start(100);
    wait_acc("t6_four", a0 + 4, 1000);
    cycles(10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done("t6_timeout", d0, 2000);
    chk("t6_nbytes", 32'(acc_q.size() - a0), 32'd5);
    chk("t6_last", 32'(acc_q[a0+4]), 32'h05);
    chk("t6_ss", 32'(ss), 32'd1);
    chk("t6_done_cnt", 32'(done_cnt - d0), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
